// File: rtl/pc_gen_pkg.sv
// Shared types and defaults for the PC generator.
// Alignment rule depends on PC_GEN_RVC_EN (16-bit instruction support).
package pc_gen_pkg;

  typedef enum logic [1:0] {
    StBoot = 2'd0,
    StRun  = 2'd1,
    StTrap = 2'd2
  } pc_state_e;

  typedef enum logic [2:0] {
    SelSeq    = 3'd0,
    SelBranch = 3'd1,
    SelJalr   = 3'd2,
    SelJal    = 3'd3,
    SelMret   = 3'd4,
    SelTrap   = 3'd5
  } pc_sel_e;

  localparam logic [31:0] DefResetVector = 32'h0000_0000;
  localparam logic [31:0] DefTrapVector  = 32'h0000_0100;

`ifdef PC_GEN_RVC_EN
  localparam logic [1:0] AlignMask = 2'b01;
`else
  localparam logic [1:0] AlignMask = 2'b11;
`endif

  function automatic logic target_misaligned(input logic [1:0] low);
    return |(low & AlignMask);
  endfunction

endpackage

// File: rtl/pc_target_sel.sv
// Combinational next-PC selector: redirect priority, target arithmetic and
// misaligned-target detection. Increment of 2 for compressed ops under PC_GEN_RVC_EN.
module pc_target_sel
  import pc_gen_pkg::*;
#(
  parameter int unsigned     XLEN        = 32,
  parameter logic [XLEN-1:0] TRAP_VECTOR = XLEN'(DefTrapVector)
) (
  input  logic [XLEN-1:0] i_pc,
  input  logic [XLEN-1:0] i_epc,
  input  logic [XLEN-1:0] i_rs1_data,
  input  logic [XLEN-1:0] i_i_imm,
  input  logic [XLEN-1:0] i_j_imm,
  input  logic [XLEN-1:0] i_b_imm,
  input  logic            i_jump_jal,
  input  logic            i_jump_jalr,
  input  logic            i_branch,
  input  logic            i_branch_taken,
  input  logic            i_trap_req,
  input  logic            i_mret,
  input  logic            i_is_compressed,
  output logic [XLEN-1:0] o_next_pc,
  output pc_sel_e         o_sel,
  output logic            o_trap,
  output logic            o_misaligned
);

  logic [XLEN-1:0] w_inc;
  logic [XLEN-1:0] w_jal_tgt;
  logic [XLEN-1:0] w_jalr_sum;
  logic [XLEN-1:0] w_jalr_tgt;
  logic [XLEN-1:0] w_br_tgt;
  logic [XLEN-1:0] w_tgt;
  logic            w_redirect;

`ifdef PC_GEN_RVC_EN
  assign w_inc = i_is_compressed ? XLEN'(2) : XLEN'(4);
`else
  logic w_unused_rvc;
  assign w_unused_rvc = i_is_compressed;
  assign w_inc        = XLEN'(4);
`endif

  assign w_jal_tgt  = i_pc + i_j_imm;
  assign w_jalr_sum = i_rs1_data + i_i_imm;
  assign w_jalr_tgt = {w_jalr_sum[XLEN-1:1], 1'b0};
  assign w_br_tgt   = i_pc + i_b_imm;

  always_comb begin
    o_sel = SelSeq;
    if (i_trap_req)                      o_sel = SelTrap;
    else if (i_mret)                     o_sel = SelMret;
    else if (i_jump_jal)                 o_sel = SelJal;
    else if (i_jump_jalr)                o_sel = SelJalr;
    else if (i_branch && i_branch_taken) o_sel = SelBranch;
  end

  always_comb begin
    w_tgt      = i_pc + w_inc;
    w_redirect = 1'b0;
    unique case (o_sel)
      SelJal:    begin w_tgt = w_jal_tgt;  w_redirect = 1'b1; end
      SelJalr:   begin w_tgt = w_jalr_tgt; w_redirect = 1'b1; end
      SelBranch: begin w_tgt = w_br_tgt;   w_redirect = 1'b1; end
      SelMret:   w_tgt = i_epc;
      SelTrap:   w_tgt = TRAP_VECTOR;
      default:   ;
    endcase
    // A misaligned redirect turns into a trap instead of being followed.
    o_misaligned = w_redirect && target_misaligned(w_tgt[1:0]);
    o_trap       = (o_sel == SelTrap) || o_misaligned;
    o_next_pc    = o_trap ? TRAP_VECTOR : w_tgt;
  end

endmodule

// File: rtl/pc_gen.sv
// Program-counter generator: BOOT/RUN/TRAP FSM, PC, EPC and fetch counter.
// Define PC_GEN_RVC_EN to enable compressed (16-bit) instruction stepping.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(DefResetVector),
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(DefTrapVector),
  parameter int unsigned     CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             fetch_ready,
  input  logic [XLEN-1:0]  rs1_data,
  input  logic [XLEN-1:0]  i_imm,
  input  logic [XLEN-1:0]  j_imm,
  input  logic [XLEN-1:0]  b_imm,
  input  logic             jump_jal,
  input  logic             jump_jalr,
  input  logic             branch,
  input  logic             branch_taken,
  input  logic             trap_req,
  input  logic             mret,
  input  logic             is_compressed,
  output logic [XLEN-1:0]  pc_out,
  output logic [XLEN-1:0]  pc_plus_4,
  output logic             fetch_valid,
  output logic [XLEN-1:0]  epc_out,
  output logic             trap_taken,
  output logic             misaligned,
  output logic [CNT_W-1:0] fetch_count
);

  pc_state_e        r_state;
  pc_state_e        w_state_d;
  logic [XLEN-1:0]  r_pc;
  logic [XLEN-1:0]  r_epc;
  logic [CNT_W-1:0] r_count;
  logic             r_trap_taken;
  logic             r_misaligned;

  logic [XLEN-1:0]  w_next_pc;
  pc_sel_e          w_sel;
  logic             w_trap;
  logic             w_mis;
  logic             w_fetch_valid;
  logic             w_advance;

  pc_target_sel #(
    .XLEN        (XLEN),
    .TRAP_VECTOR (TRAP_VECTOR)
  ) u_target_sel (
    .i_pc            (r_pc),
    .i_epc           (r_epc),
    .i_rs1_data      (rs1_data),
    .i_i_imm         (i_imm),
    .i_j_imm         (j_imm),
    .i_b_imm         (b_imm),
    .i_jump_jal      (jump_jal),
    .i_jump_jalr     (jump_jalr),
    .i_branch        (branch),
    .i_branch_taken  (branch_taken),
    .i_trap_req      (trap_req),
    .i_mret          (mret),
    .i_is_compressed (is_compressed),
    .o_next_pc       (w_next_pc),
    .o_sel           (w_sel),
    .o_trap          (w_trap),
    .o_misaligned    (w_mis)
  );

  logic w_unused_sel;
  assign w_unused_sel = ^w_sel;

  assign w_fetch_valid = (r_state == StRun);
  assign w_advance     = (r_state == StRun) && w_fetch_valid && fetch_ready && !stall;

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StBoot:  w_state_d = StRun;
      StRun:   if (w_advance && w_trap) w_state_d = StTrap;
      StTrap:  w_state_d = StRun;
      default: w_state_d = StBoot;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= StBoot;
      r_pc         <= RESET_VECTOR;
      r_epc        <= '0;
      r_count      <= '0;
      r_trap_taken <= 1'b0;
      r_misaligned <= 1'b0;
    end else begin
      r_state      <= w_state_d;
      r_trap_taken <= w_advance && w_trap;
      r_misaligned <= w_advance && w_mis;
      if (w_advance) begin
        r_pc    <= w_next_pc;
        r_count <= r_count + CNT_W'(1);
        if (w_trap) r_epc <= r_pc;
      end
    end
  end

  assign pc_out      = r_pc;
  assign pc_plus_4   = r_pc + XLEN'(4);
  assign fetch_valid = w_fetch_valid;
  assign epc_out     = r_epc;
  assign trap_taken  = r_trap_taken;
  assign misaligned  = r_misaligned;
  assign fetch_count = r_count;

endmodule

// File: tb/tb_pc_gen.sv
// Directed, table-driven bench for pc_gen plus hand-written trap/reset/wrap sequences.
// Compressed-step checks are compiled in when PC_GEN_RVC_EN is defined.
module tb_pc_gen;

  logic        clk, rst_n, stall, fetch_ready;
  logic        jump_jal, jump_jalr, branch, branch_taken, trap_req, mret, is_compressed;
  logic [31:0] rs1_data, i_imm, j_imm, b_imm;
  logic [31:0] pc_out, pc_plus_4, epc_out, fetch_count;
  logic        fetch_valid, trap_taken, misaligned;
  logic [31:0] pc2, pc2_p4, epc2;
  logic [2:0]  cnt2;
  logic        fv2, tt2, mis2;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic        jal, jalr, br, tk, trq, mrt, stl, rdy;
    logic [31:0] rs1, ii, jj, bb;
    logic [31:0] e_pc, e_epc, e_cnt;
    logic        e_tt, e_mis;
  } vec_t;

  vec_t tbl[15];

  pc_gen dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .fetch_ready(fetch_ready),
    .rs1_data(rs1_data), .i_imm(i_imm), .j_imm(j_imm), .b_imm(b_imm),
    .jump_jal(jump_jal), .jump_jalr(jump_jalr), .branch(branch),
    .branch_taken(branch_taken), .trap_req(trap_req), .mret(mret),
    .is_compressed(is_compressed), .pc_out(pc_out), .pc_plus_4(pc_plus_4),
    .fetch_valid(fetch_valid), .epc_out(epc_out), .trap_taken(trap_taken),
    .misaligned(misaligned), .fetch_count(fetch_count)
  );

  // Narrow counter and non-zero reset vector, used for the wrap check.
  pc_gen #(.RESET_VECTOR(32'h0000_1000), .CNT_W(3)) dut2 (
    .clk(clk), .rst_n(rst_n), .stall(stall), .fetch_ready(fetch_ready),
    .rs1_data(rs1_data), .i_imm(i_imm), .j_imm(j_imm), .b_imm(b_imm),
    .jump_jal(jump_jal), .jump_jalr(jump_jalr), .branch(branch),
    .branch_taken(branch_taken), .trap_req(trap_req), .mret(mret),
    .is_compressed(is_compressed), .pc_out(pc2), .pc_plus_4(pc2_p4),
    .fetch_valid(fv2), .epc_out(epc2), .trap_taken(tt2),
    .misaligned(mis2), .fetch_count(cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic jal, jalr, br, tk, trq, mrt, stl, rdy,
                              input logic [31:0] rs1, ii, jj, bb, e_pc, e_epc, e_cnt,
                              input logic e_tt, e_mis);
    vec_t v;
    v.jal = jal; v.jalr = jalr; v.br = br; v.tk = tk; v.trq = trq; v.mrt = mrt;
    v.stl = stl; v.rdy = rdy; v.rs1 = rs1; v.ii = ii; v.jj = jj; v.bb = bb;
    v.e_pc = e_pc; v.e_epc = e_epc; v.e_cnt = e_cnt; v.e_tt = e_tt; v.e_mis = e_mis;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    stall = 0; fetch_ready = 1; jump_jal = 0; jump_jalr = 0; branch = 0;
    branch_taken = 0; trap_req = 0; mret = 0; is_compressed = 0;
    rs1_data = 0; i_imm = 0; j_imm = 0; b_imm = 0;
  endtask

  task automatic apply(input vec_t v);
    jump_jal = v.jal; jump_jalr = v.jalr; branch = v.br; branch_taken = v.tk;
    trap_req = v.trq; mret = v.mrt; stall = v.stl; fetch_ready = v.rdy;
    rs1_data = v.rs1; i_imm = v.ii; j_imm = v.jj; b_imm = v.bb;
  endtask

  task automatic chk_out(input string nm, input logic [31:0] e_pc, input logic [31:0] e_epc,
                         input logic [31:0] e_cnt, input logic e_tt, input logic e_mis);
    chk({nm, " pc"}, pc_out, e_pc);
    chk({nm, " pc+4"}, pc_plus_4, e_pc + 32'd4);
    chk({nm, " epc"}, epc_out, e_epc);
    chk({nm, " count"}, fetch_count, e_cnt);
    chk({nm, " trap_taken"}, {31'd0, trap_taken}, {31'd0, e_tt});
    chk({nm, " misaligned"}, {31'd0, misaligned}, {31'd0, e_mis});
  endtask

  initial begin
    logic [31:0] bmis;
`ifdef PC_GEN_RVC_EN
    bmis = 32'h5;
`else
    bmis = 32'h6;
`endif
    //            jal jalr br tk trq mrt stl rdy rs1   ii    jj            bb
    tbl[0]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 32'h10, 0, 4, 0, 0);
    tbl[1]  = mk(0, 1, 0, 0, 0, 0, 0, 1, 32'h101, 32'h20, 0, 0, 32'h120, 0, 5, 0, 0);
    tbl[2]  = mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 32'hFFFF_FEF0, 0, 32'h10, 0, 6, 0, 0);
    tbl[3]  = mk(0, 0, 1, 1, 0, 0, 0, 1, 0, 0, 0, bmis, 32'h100, 32'h10, 7, 1, 1);
    tbl[4]  = mk(0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 32'h40, 32'h104, 32'h10, 8, 0, 0);
    tbl[5]  = mk(0, 0, 1, 1, 0, 0, 0, 1, 0, 0, 0, 32'hFFFF_FFFC, 32'h100, 32'h10, 9, 0, 0);
    tbl[6]  = mk(0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 32'h10, 32'h10, 10, 0, 0);
    tbl[7]  = mk(1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 32'h30, 0, 32'h10, 32'h10, 10, 0, 0);
    tbl[8]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h30, 0, 32'h10, 32'h10, 10, 0, 0);
    tbl[9]  = mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 32'h30, 0, 32'h40, 32'h10, 11, 0, 0);
    tbl[10] = mk(1, 1, 0, 0, 0, 0, 0, 1, 32'h500, 0, 32'h40, 0, 32'h80, 32'h10, 12, 0, 0);
    tbl[11] = mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 32'h1, 0, 32'h100, 32'h80, 13, 1, 1);
    tbl[12] = mk(0, 0, 0, 0, 1, 1, 0, 1, 0, 0, 0, 0, 32'h100, 32'h100, 14, 1, 0);
    tbl[13] = mk(0, 1, 1, 1, 0, 0, 0, 1, 32'h301, 0, 0, 32'h8, 32'h300, 32'h100, 15, 0, 0);
    tbl[14] = mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 32'hFFFF_FD00, 0, 32'h0, 32'h100, 16, 0, 0);

    // Reset and boot
    idle();
    rst_n = 1'b0;
    #12;
    chk_out("reset", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    chk("reset fetch_valid", {31'd0, fetch_valid}, 32'd0);
    chk("reset dut2 pc", pc2, 32'h1000);
    rst_n = 1'b1;
    #1;
    chk("boot fetch_valid", {31'd0, fetch_valid}, 32'd0);
    step();
    chk("first fetch_valid", {31'd0, fetch_valid}, 32'd1);
    chk_out("boot", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    for (int k = 1; k <= 3; k++) begin
      step();
      chk_out($sformatf("seq%0d", k), 32'(4 * k), 32'h0, 32'(k), 1'b0, 1'b0);
    end

    // Table: each record chains from the PC left by the previous one
    for (int i = 0; i < 15; i++) begin
      apply(tbl[i]);
      step();
      idle();
      chk_out($sformatf("v%0d", i), tbl[i].e_pc, tbl[i].e_epc, tbl[i].e_cnt,
              tbl[i].e_tt, tbl[i].e_mis);
      if (tbl[i].e_tt) begin
        chk($sformatf("v%0d bubble fetch_valid", i), {31'd0, fetch_valid}, 32'd0);
        jump_jal = 1; j_imm = 32'h44;
        step();
        idle();
        chk($sformatf("v%0d post-bubble fetch_valid", i), {31'd0, fetch_valid}, 32'd1);
        chk_out($sformatf("v%0d post-bubble", i), tbl[i].e_pc, tbl[i].e_epc, tbl[i].e_cnt,
                1'b0, 1'b0);
      end else begin
        chk($sformatf("v%0d fetch_valid", i), {31'd0, fetch_valid}, 32'd1);
      end
    end

    // Stalled trap request is deferred, then mret returns
    jump_jal = 1; j_imm = 32'h40;
    step();
    idle();
    chk_out("to 0x40", 32'h40, 32'h100, 32'd17, 1'b0, 1'b0);
    trap_req = 1; stall = 1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk_out($sformatf("stalled trap%0d", k), 32'h40, 32'h100, 32'd17, 1'b0, 1'b0);
    end
    stall = 0;
    step();
    idle();
    chk_out("deferred trap", 32'h100, 32'h40, 32'd18, 1'b1, 1'b0);
    chk("deferred trap bubble", {31'd0, fetch_valid}, 32'd0);
    step();
    chk_out("after trap", 32'h100, 32'h40, 32'd18, 1'b0, 1'b0);
    mret = 1;
    step();
    idle();
    chk_out("mret", 32'h40, 32'h40, 32'd19, 1'b0, 1'b0);

    // Asynchronous reset in the middle of TRAP
    trap_req = 1;
    step();
    idle();
    chk("pre-reset trap_taken", {31'd0, trap_taken}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk_out("async reset", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    chk("async reset fetch_valid", {31'd0, fetch_valid}, 32'd0);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("reboot fetch_valid", {31'd0, fetch_valid}, 32'd1);

    // Counter wrap on the 3-bit instance
    for (int k = 1; k <= 8; k++) step();
    chk("dut2 count wrap", {29'd0, cnt2}, 32'd0);
    chk("dut2 pc", pc2, 32'h1020);
    chk("dut2 pc+4", pc2_p4, 32'h1024);
    chk("dut2 epc", epc2, 32'h0);
    chk("dut2 pulses", {30'd0, tt2, mis2}, 32'd0);
    chk("dut2 fetch_valid", {31'd0, fv2}, 32'd1);
    chk_out("post-wrap main", 32'h20, 32'h0, 32'd8, 1'b0, 1'b0);

`ifdef PC_GEN_RVC_EN
    jump_jal = 1; j_imm = 32'hFFFF_FFE8;
    step();
    idle();
    chk_out("rvc to 0x8", 32'h8, 32'h0, 32'd9, 1'b0, 1'b0);
    is_compressed = 1;
    step();
    idle();
    chk_out("rvc compressed", 32'hA, 32'h0, 32'd10, 1'b0, 1'b0);
    jump_jal = 1; j_imm = 32'hF8;
    step();
    idle();
    chk_out("rvc jal 0x102", 32'h102, 32'h0, 32'd11, 1'b0, 1'b0);
`else
    is_compressed = 1;
    step();
    idle();
    chk_out("compressed ignored", 32'h24, 32'h0, 32'd9, 1'b0, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pc_gen.md
PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 Parameter XLEN, default 32, width of PC, operands and targets.
REQ-002 Parameter RESET_VECTOR, default 32'h0000_0000, PC loaded at reset.
REQ-003 Parameter TRAP_VECTOR, default 32'h0000_0100, PC loaded on trap entry.
REQ-004 Parameter CNT_W, default 32, width of accepted-fetch counter.
REQ-005 One clock and an asynchronous, active-low reset; ports `clk` and `rst_n`.
REQ-006 Port `clk`, input, 1, rising-edge clock.
REQ-007 Port `rst_n`, input, 1, asynchronous active-low reset.
REQ-008 Port `stall`, input, 1, freezes PC and counter.
REQ-009 Port `fetch_ready`, input, 1, instruction memory accepts `pc_out`.
REQ-010 Port `rs1_data`, input, XLEN, JALR base.
REQ-011 Ports `i_imm`, `j_imm`, `b_imm`, input, XLEN each, sign-extended immediates.
REQ-012 Ports `jump_jal`, `jump_jalr`, `branch`, `branch_taken`, input, 1 each, redirect controls.
REQ-013 Ports `trap_req` and `mret`, input, 1 each, external trap request and trap return.
REQ-014 Port `is_compressed`, input, 1, current instruction is 16-bit; used only under RVC_EN.
REQ-015 Port `pc_out`, output, XLEN, current fetch address.
REQ-016 Port `pc_plus_4`, output, XLEN, `pc_out`+4 for link writeback.
REQ-017 Port `fetch_valid`, output, 1, `pc_out` is a valid fetch request.
REQ-018 Port `epc_out`, output, XLEN, saved exception PC.
REQ-019 Port `trap_taken`, output, 1, one-cycle pulse on trap entry.
REQ-020 Port `misaligned`, output, 1, one-cycle pulse when the trap cause is a misaligned target.
REQ-021 Port `fetch_count`, output, CNT_W, number of accepted fetches.

Function
REQ-022 FSM states are BOOT, RUN and TRAP; BOOT and TRAP drive `fetch_valid`=0 and always advance to RUN after one cycle.
REQ-023 Advance condition is state RUN && `fetch_valid` && `fetch_ready` && !`stall`; without it, PC, counter and EPC hold.
REQ-024 On advance, next-PC priority is `trap_req` > `mret` > `jump_jal` > `jump_jalr` > (`branch` && `branch_taken`) > sequential.
REQ-025 Next-PC targets:
- JAL: `pc_out`+`j_imm`.
- JALR: (`rs1_data`+`i_imm`) with bit0 cleared.
- Branch: `pc_out`+`b_imm`.
- Sequential: `pc_out`+4.
- All sums are modulo 2^XLEN.
REQ-026 `trap_req` on advance saves `pc_out` to EPC, loads TRAP_VECTOR, enters TRAP and pulses `trap_taken`.
REQ-027 A selected JAL, JALR or branch target with a misaligned bit causes a trap instead of the redirect: EPC=`pc_out`, PC=TRAP_VECTOR, `trap_taken` and `misaligned` pulse, state TRAP.
REQ-028 `mret` on advance loads EPC into PC with no trap pulse.
REQ-029 `fetch_count` increments by 1 on each advance, wraps from all-ones to 0, and is not incremented by BOOT or TRAP cycles.
REQ-030 `stall` asserted together with `trap_req` defers the trap until the first unstalled ready cycle.
REQ-031 Control inputs are sampled only on advance cycles and are ignored in BOOT and TRAP.

Reset
REQ-032 Assertion of `rst_n` (low), asynchronous, drives the following and aborts any in-progress trap entry:
- PC=RESET_VECTOR, EPC=0, `fetch_count`=0, state=BOOT.
- `fetch_valid`=0, `trap_taken`=0, `misaligned`=0.
REQ-033 First `fetch_valid`=1 occurs in the second rising edge after `rst_n` deasserts.

Configuration
REQ-034 Macro PC_GEN_RVC_EN:
- Defined: sequential increment is 2 when `is_compressed`=1, else 4; a target is misaligned only if bit0 is set.
- Undefined: `is_compressed` is ignored, increment is always 4, and a target is misaligned if bit1 or bit0 is set.

Structure
REQ-035 Shared package `pc_gen_pkg` holds the FSM state encoding, the next-PC select encoding and the default vectors.
REQ-036 Sub-module `pc_target_sel` is the combinational target/priority/misalignment selector; `pc_gen` holds FSM and registers.

Verification
REQ-037 Release reset, keep `fetch_ready`=1 -> `fetch_valid` rises second cycle; PC sequence 0,4,8; `fetch_count` 1,2,3.
REQ-038 At PC=0x10, `jump_jalr`=1, `rs1_data`=0x101, `i_imm`=0x20 -> next PC 0x120.
REQ-039 At PC=0x10, `branch`=1, `branch_taken`=1, `b_imm`=0x6, RVC_EN undefined -> `trap_taken`=1 and `misaligned`=1, EPC=0x10, PC=0x100, one bubble cycle.
REQ-040 At PC=0x40, `trap_req` with `stall`=1 for 3 cycles -> PC holds 0x40; on release, trap enters and EPC=0x40; then `mret` -> PC=0x40.
REQ-041 Assert `rst_n` low mid-TRAP -> all outputs take reset values immediately, without waiting for a clock edge.
REQ-042 With RVC_EN defined, `is_compressed`=1 at PC=0x8 -> next PC 0xA; JAL to 0x102 -> no trap.
